inst_fetch: RTL and testbench



---
 rtl/inst_fetch.sv | 134 +++++++++++++
 tb/tb_inst_fetch.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps one SRAM request in flight,
// and hands (pc, inst) to decode through a ready/valid register backed by a 1-entry skid buffer.
module inst_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h1c00_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  inst_sram_req,
  output logic [ADDR_WIDTH-1:0] inst_sram_addr,
  input  logic                  inst_sram_addr_ok,
  input  logic                  inst_sram_data_ok,
  input  logic [INST_WIDTH-1:0] inst_sram_rdata,
  input  logic                  branch_en,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  input  logic                  id_ready,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [INST_WIDTH-1:0] if_inst
);

  // Handshake: decode takes if_pc/if_inst in any cycle where if_valid && id_ready
  // ("fire"); if_valid/if_pc/if_inst are held stable until that cycle.
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic [INST_WIDTH-1:0] buf_inst_q, buf_inst_d;
  logic                  if_valid_q, if_valid_d;
  logic [ADDR_WIDTH-1:0] if_pc_q, if_pc_d;
  logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;

  logic                  fire;
  logic                  redirect;
  logic                  deliver;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] target;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;

    fire     = if_valid_q & id_ready;
    redirect = fire & (branch_en | jump_en);
    target   = branch_en ? branch_addr : jump_addr;
    // No new request while the skid slot is full, so every return has somewhere to land.
    inst_sram_req  = (state_q == S_REQ) & ~buf_valid_q & ~rst;
    inst_sram_addr = fetch_pc_q;
    accept   = inst_sram_req & inst_sram_addr_ok;
    deliver  = (state_q == S_WAIT) & inst_sram_data_ok;

    case (state_q)
      S_REQ: begin
        if (accept) begin
          req_addr_d = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
          state_d    = S_WAIT;
        end
      end
      S_WAIT: if (inst_sram_data_ok) state_d = S_REQ;
      S_DROP: if (inst_sram_data_ok) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    if (deliver && (!if_valid_q || fire)) begin
      if_valid_d = 1'b1;
      if_pc_d    = req_addr_q;
      if_inst_d  = inst_sram_rdata;
    end else if (deliver) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = req_addr_q;
      buf_inst_d  = inst_sram_rdata;
    end else if (fire) begin
      if (buf_valid_q) begin
        if_pc_d     = buf_pc_q;
        if_inst_d   = buf_inst_q;
        buf_valid_d = 1'b0;
      end else begin
        if_valid_d = 1'b0;
      end
    end

    // A redirect squashes everything younger than the instruction decode just took.
    if (redirect) begin
      fetch_pc_d  = target;
      buf_valid_d = 1'b0;
      if_valid_d  = 1'b0;
      if (state_q == S_WAIT) state_d = inst_sram_data_ok ? S_REQ : S_DROP;
      else if (accept)       state_d = S_DROP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= '0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= '0;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_inst_q   <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: inputs change on the falling edge, outputs are checked 1ns later.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic [31:0] rdata = '0;
  logic        branch_en = 1'b0;
  logic [31:0] branch_addr = '0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = '0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int vectors = 0;
  int miscompares = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst),
    .inst_sram_req(req), .inst_sram_addr(addr),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok), .inst_sram_rdata(rdata),
    .branch_en(branch_en), .branch_addr(branch_addr),
    .jump_en(jump_en), .jump_addr(jump_addr),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, "_pc"}, if_pc, pc);
    chk({tag, "_inst"}, if_inst, inst);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] a);
    chk({tag, "_req"}, {31'd0, req}, 32'd1);
    chk({tag, "_addr"}, addr, a);
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // reset
    nxt();
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_inst", if_inst, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // streaming with a one-cycle slave
    chk_req("s0", 32'h1c00_0000);
    addr_ok = 1'b1;
    nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_0000;
    chk("s1_req", {31'd0, req}, 32'd0);
    chk("s1_valid", {31'd0, if_valid}, 32'd0);
    nxt(); data_ok = 1'b0; addr_ok = 1'b1;
    chk_out("s2", 32'h1c00_0000, 32'h1111_0000);
    chk_req("s2", 32'h1c00_0004);
    nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_0001;
    chk("s3_valid", {31'd0, if_valid}, 32'd0);
    nxt(); data_ok = 1'b0;
    chk_out("s4", 32'h1c00_0004, 32'h1111_0001);
    chk_req("s4", 32'h1c00_0008);

    // back-pressure: 08 lands in the skid buffer, requests stop
    id_ready = 1'b0; addr_ok = 1'b1;
    nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_0002;
    chk_out("bp5", 32'h1c00_0004, 32'h1111_0001);
    nxt(); data_ok = 1'b0;
    chk("bp6_req", {31'd0, req}, 32'd0);
    chk_out("bp6", 32'h1c00_0004, 32'h1111_0001);
    nxt();
    chk("bp7_req", {31'd0, req}, 32'd0);
    nxt(); id_ready = 1'b1;
    chk_out("bp8", 32'h1c00_0004, 32'h1111_0001);
    chk("bp8_req", {31'd0, req}, 32'd0);
    nxt(); addr_ok = 1'b1;
    chk_out("bp9", 32'h1c00_0008, 32'h1111_0002);
    chk_req("bp9", 32'h1c00_000c);
    nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_0003;
    chk("bp10_valid", {31'd0, if_valid}, 32'd0);
    nxt(); data_ok = 1'b0; addr_ok = 1'b1;
    chk_out("bp11", 32'h1c00_000c, 32'h1111_0003);
    chk_req("bp11", 32'h1c00_0010);
    nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h1111_0004;

    // jump fires while the 14 request waits in S_WAIT
    nxt(); data_ok = 1'b0; addr_ok = 1'b1; id_ready = 1'b0;
    chk_out("j13", 32'h1c00_0010, 32'h1111_0004);
    chk_req("j13", 32'h1c00_0014);
    nxt(); addr_ok = 1'b0; id_ready = 1'b1; jump_en = 1'b1; jump_addr = 32'h1c00_0100;
    chk_out("j14", 32'h1c00_0010, 32'h1111_0004);
    nxt(); jump_en = 1'b0; data_ok = 1'b1; rdata = 32'hdead_0014;
    chk("j15_req", {31'd0, req}, 32'd0);
    chk("j15_valid", {31'd0, if_valid}, 32'd0);
    nxt(); data_ok = 1'b0;
    chk("j16_valid", {31'd0, if_valid}, 32'd0);
    chk_req("j16", 32'h1c00_0100);
    addr_ok = 1'b1;
    nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h2222_0100;
    nxt(); data_ok = 1'b0;
    chk_out("j18", 32'h1c00_0100, 32'h2222_0100);
    chk_req("j18", 32'h1c00_0104);

    // branch coincident with data_ok in S_WAIT
    addr_ok = 1'b1; id_ready = 1'b0;
    nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'hdead_0104;
    id_ready = 1'b1; branch_en = 1'b1; branch_addr = 32'h1c00_0180;
    nxt(); data_ok = 1'b0; branch_en = 1'b0;
    chk("d20_valid", {31'd0, if_valid}, 32'd0);
    chk_req("d20", 32'h1c00_0180);
    addr_ok = 1'b1;
    nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h3333_0180;

    // jump coincident with req & addr_ok
    nxt(); data_ok = 1'b0;
    chk_out("a22", 32'h1c00_0180, 32'h3333_0180);
    chk_req("a22", 32'h1c00_0184);
    addr_ok = 1'b1; jump_en = 1'b1; jump_addr = 32'h1c00_0240;
    nxt(); addr_ok = 1'b0; jump_en = 1'b0; data_ok = 1'b1; rdata = 32'hdead_0184;
    chk("a23_req", {31'd0, req}, 32'd0);
    chk("a23_valid", {31'd0, if_valid}, 32'd0);
    nxt(); data_ok = 1'b0;
    chk("a24_valid", {31'd0, if_valid}, 32'd0);
    chk_req("a24", 32'h1c00_0240);
    addr_ok = 1'b1;
    nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h4444_0240;

    // branch and jump together, no addr_ok: branch target wins
    nxt(); data_ok = 1'b0;
    chk_out("p26", 32'h1c00_0240, 32'h4444_0240);
    branch_en = 1'b1; branch_addr = 32'h1c00_0200;
    jump_en = 1'b1; jump_addr = 32'h1c00_0300;
    nxt(); branch_en = 1'b0; jump_en = 1'b0;
    chk("p27_valid", {31'd0, if_valid}, 32'd0);
    chk_req("p27", 32'h1c00_0200);
    addr_ok = 1'b1;
    nxt(); addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h5555_0200;

    // async reset while 204 is in S_WAIT
    nxt(); data_ok = 1'b0; id_ready = 1'b0; addr_ok = 1'b1;
    chk_out("r29", 32'h1c00_0200, 32'h5555_0200);
    chk_req("r29", 32'h1c00_0204);
    nxt(); addr_ok = 1'b0;
    chk_out("r30", 32'h1c00_0200, 32'h5555_0200);
    rst = 1'b1;
    #1;
    chk("r30_valid", {31'd0, if_valid}, 32'd0);
    chk("r30_pc", if_pc, 32'd0);
    chk("r30_req", {31'd0, req}, 32'd0);
    @(negedge clk);
    rst = 1'b0; data_ok = 1'b1; rdata = 32'hdead_0204; id_ready = 1'b1;
    #1;
    chk_req("r31", 32'h1c00_0000);
    nxt(); data_ok = 1'b0;
    chk("r32_valid", {31'd0, if_valid}, 32'd0);
    chk_req("r32", 32'h1c00_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
